// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer, the receive end of a word-serial TDM link.
// Words arrive one channel at a time (channel 0 flagged by in_sync). They are collected
// into a shadow register and published atomically on out_data once a whole frame has
// arrived. Frame alignment is tracked by a HUNT/RUN state machine.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/in_sync carry a word this cycle
//   in_data    channel sample (W bits)
//   in_sync    marks the channel-0 word of a frame
//   out_data   last complete frame, channel k at [k*W +: W]
//   out_valid  one-cycle pulse when out_data has just been updated
//   ch_idx     channel slot the next accepted word will fill
//   locked     high while aligned (RUN)
//   sync_err   one-cycle pulse on an alignment error
//   frame_cnt  completed frames, wrapping at 8 bits
module tdm_demux #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8,
  localparam int unsigned CW  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [W-1:0]        in_data,
  input  logic                in_sync,
  output logic [N_CH*W-1:0]   out_data,
  output logic                out_valid,
  output logic [CW-1:0]       ch_idx,
  output logic                locked,
  output logic                sync_err,
  output logic [7:0]          frame_cnt
);

  typedef enum logic [0:0] {StHunt, StRun} state_e;

  localparam logic [CW-1:0] LastCh = CW'(N_CH - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       ch_idx_q, ch_idx_d;
  logic [N_CH*W-1:0]   shadow_q, shadow_d;
  logic [N_CH*W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                sync_err_q, sync_err_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (in_valid) begin
      case (state_q)
        StHunt: begin
          // Unaligned words are dropped until a sync word starts a frame.
          if (in_sync) begin
            shadow_d[W-1:0] = in_data;
            ch_idx_d        = CW'(1);
            state_d         = StRun;
          end
        end
        StRun: begin
          if (in_sync) begin
            // A sync mid-frame restarts the frame; the partial one is abandoned.
            // Its stale lanes are rewritten in order before the next completion.
            sync_err_d      = (ch_idx_q != '0);
            shadow_d[W-1:0] = in_data;
            ch_idx_d        = CW'(1);
          end else if (ch_idx_q == '0) begin
            // Expected a frame start but got a data word: alignment lost.
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else begin
            shadow_d[ch_idx_q*W +: W] = in_data;
            if (ch_idx_q == LastCh) begin
              out_data_d  = shadow_d;
              out_valid_d = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
              ch_idx_d    = '0;
            end else begin
              ch_idx_d = ch_idx_q + CW'(1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      ch_idx_q    <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ch_idx    = ch_idx_q;
  assign locked    = (state_q == StRun);
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
